// File: rtl/uart_rx_frame_deser.sv
// UART receive deserializer and frame checker: collects sampler strobes into a parallel word with parity/stop flags.
// Optional build macro UART_RX_DESER_HOLD_EN turns Data_Valid into a held level with Rd_Ack handshake and an Overrun flag.
module uart_rx_frame_deser #(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start_Det,
  input  logic                  Sample_Valid,
  input  logic                  Sample_Data,
  input  logic                  Par_En,
  input  logic                  Par_Typ,
  input  logic                  Abort,
  input  logic                  Rd_Ack,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stop_Err,
  output logic                  Busy
`ifdef UART_RX_DESER_HOLD_EN
  ,
  output logic                  Overrun
`endif
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  run_par_q, run_par_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_out_q, par_err_out_d;
  logic                  stop_err_out_q, stop_err_out_d;
  logic                  overrun_q, overrun_d;
  logic [CW-1:0]         data_idx;

  assign data_idx = (MSB_FIRST != 0) ? (CW'(DATA_WIDTH - 1) - cnt_q) : cnt_q;

  // Abort outranks every other input; in IDLE it also swallows a same-cycle Start_Det.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    run_par_d      = run_par_q;
    par_en_d       = par_en_q;
    par_typ_d      = par_typ_q;
    par_err_d      = par_err_q;
    stop_err_d     = stop_err_q;
    stop_cnt_d     = stop_cnt_q;
    p_data_d       = p_data_q;
    par_err_out_d  = par_err_out_q;
    stop_err_out_d = stop_err_out_q;
`ifdef UART_RX_DESER_HOLD_EN
    data_valid_d   = data_valid_q & ~Rd_Ack;
    overrun_d      = overrun_q & ~Rd_Ack;
`else
    data_valid_d   = 1'b0;
    overrun_d      = 1'b0;
`endif
    if (state_q == S_IDLE) begin
      if (!Abort && Start_Det) begin
        state_d    = S_DATA;
        cnt_d      = '0;
        shift_d    = '0;
        run_par_d  = 1'b0;
        par_en_d   = Par_En;
        par_typ_d  = Par_Typ;
        par_err_d  = 1'b0;
        stop_err_d = 1'b0;
        stop_cnt_d = 1'b0;
      end
    end else if (Abort) begin
      state_d = S_IDLE;
    end else if (Sample_Valid) begin
      case (state_q)
        S_DATA: begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (data_idx == CW'(i)) shift_d[i] = Sample_Data;
          end
          run_par_d = run_par_q ^ Sample_Data;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_WIDTH - 1)) state_d = par_en_q ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          if (Sample_Data != (run_par_q ^ par_typ_q)) par_err_d = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
        default: begin
          if (!Sample_Data) stop_err_d = 1'b1;
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            p_data_d       = shift_q;
            par_err_out_d  = par_err_q;
            stop_err_out_d = stop_err_q | ~Sample_Data;
            data_valid_d   = 1'b1;
`ifdef UART_RX_DESER_HOLD_EN
            if (data_valid_q && !Rd_Ack) overrun_d = 1'b1;
`endif
            state_d        = S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      run_par_q      <= 1'b0;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      par_err_q      <= 1'b0;
      stop_err_q     <= 1'b0;
      stop_cnt_q     <= 1'b0;
      p_data_q       <= '0;
      data_valid_q   <= 1'b0;
      par_err_out_q  <= 1'b0;
      stop_err_out_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      run_par_q      <= run_par_d;
      par_en_q       <= par_en_d;
      par_typ_q      <= par_typ_d;
      par_err_q      <= par_err_d;
      stop_err_q     <= stop_err_d;
      stop_cnt_q     <= stop_cnt_d;
      p_data_q       <= p_data_d;
      data_valid_q   <= data_valid_d;
      par_err_out_q  <= par_err_out_d;
      stop_err_out_q <= stop_err_out_d;
      overrun_q      <= overrun_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = data_valid_q;
  assign Par_Err    = par_err_out_q;
  assign Stop_Err   = stop_err_out_q;
  assign Busy       = (state_q != S_IDLE);

`ifdef UART_RX_DESER_HOLD_EN
  assign Overrun = overrun_q;
`else
  logic unused_hold_sigs;
  assign unused_hold_sigs = Rd_Ack ^ overrun_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame_deser.sv
// Scoreboard bench for uart_rx_frame_deser: three parameter variants share stimulus, one is watched at a time.
// Build with UART_RX_DESER_HOLD_EN defined to also exercise the held Data_Valid / Overrun behaviour.
module tb_uart_rx_frame_deser;

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       se;
    int         due;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic Start_Det = 1'b0, Sample_Valid = 1'b0, Sample_Data = 1'b0;
  logic Par_En = 1'b0, Par_Typ = 1'b0, Abort = 1'b0, Rd_Ack = 1'b0;

  logic [7:0] pd0, pd1;
  logic [6:0] pd2;
  logic dv0, dv1, dv2, pe0, pe1, pe2, se0, se1, se2, bz0, bz1, bz2;
  logic ov0, ov1, ov2;

  int   cyc = 0;
  int   sel = 0;
  int   nChecks = 0;
  int   nFails = 0;
  exp_t sbq[$];

  logic [8:0] monData;
  logic monDv, monPe, monSe, monBusy, monOv;

  uart_rx_frame_deser u0 (
    .CLK(CLK), .RST(RST), .Start_Det(Start_Det), .Sample_Valid(Sample_Valid),
    .Sample_Data(Sample_Data), .Par_En(Par_En), .Par_Typ(Par_Typ), .Abort(Abort),
    .Rd_Ack(Rd_Ack), .P_DATA(pd0), .Data_Valid(dv0), .Par_Err(pe0), .Stop_Err(se0),
    .Busy(bz0)
`ifdef UART_RX_DESER_HOLD_EN
    , .Overrun(ov0)
`endif
  );

  uart_rx_frame_deser #(.DATA_WIDTH(8), .MSB_FIRST(0), .STOP_BITS(2)) u1 (
    .CLK(CLK), .RST(RST), .Start_Det(Start_Det), .Sample_Valid(Sample_Valid),
    .Sample_Data(Sample_Data), .Par_En(Par_En), .Par_Typ(Par_Typ), .Abort(Abort),
    .Rd_Ack(Rd_Ack), .P_DATA(pd1), .Data_Valid(dv1), .Par_Err(pe1), .Stop_Err(se1),
    .Busy(bz1)
`ifdef UART_RX_DESER_HOLD_EN
    , .Overrun(ov1)
`endif
  );

  uart_rx_frame_deser #(.DATA_WIDTH(7), .MSB_FIRST(1), .STOP_BITS(1)) u2 (
    .CLK(CLK), .RST(RST), .Start_Det(Start_Det), .Sample_Valid(Sample_Valid),
    .Sample_Data(Sample_Data), .Par_En(Par_En), .Par_Typ(Par_Typ), .Abort(Abort),
    .Rd_Ack(Rd_Ack), .P_DATA(pd2), .Data_Valid(dv2), .Par_Err(pe2), .Stop_Err(se2),
    .Busy(bz2)
`ifdef UART_RX_DESER_HOLD_EN
    , .Overrun(ov2)
`endif
  );

`ifndef UART_RX_DESER_HOLD_EN
  assign ov0 = 1'b0;
  assign ov1 = 1'b0;
  assign ov2 = 1'b0;
`endif

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Route the currently watched instance onto the monitor bus.
  always_comb begin
    monData = {1'b0, pd0};
    monDv   = dv0;
    monPe   = pe0;
    monSe   = se0;
    monBusy = bz0;
    monOv   = ov0;
    if (sel == 1) begin
      monData = {1'b0, pd1}; monDv = dv1; monPe = pe1; monSe = se1; monBusy = bz1; monOv = ov1;
    end else if (sel == 2) begin
      monData = {2'b0, pd2}; monDv = dv2; monPe = pe2; monSe = se2; monBusy = bz2; monOv = ov2;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each expected frame is due on one exact cycle; any other Data_Valid pulse is spurious.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        checkOutput("frame_dv", 32'(monDv), 32'd1);
        checkOutput("frame_data", 32'(monData), 32'(e.data));
        checkOutput("frame_par_err", 32'(monPe), 32'(e.pe));
        checkOutput("frame_stop_err", 32'(monSe), 32'(e.se));
      end else begin
`ifndef UART_RX_DESER_HOLD_EN
        checkOutput("spurious_dv", 32'(monDv), 32'd0);
`endif
      end
      if (sbq.size() > 0 && sbq[0].due < cyc) begin
        e = sbq.pop_front();
        checkOutput("frame_missed", 32'(e.due), 32'(cyc));
      end
    end
  end

  task automatic idleCycle();
    @(posedge CLK); #1;
  endtask

  task automatic startFrame(input logic pe, input logic pt, input logic withSample);
    Par_En = pe; Par_Typ = pt; Start_Det = 1'b1;
    Sample_Valid = withSample; Sample_Data = withSample;
    idleCycle();
    Start_Det = 1'b0; Sample_Valid = 1'b0; Sample_Data = 1'b0;
  endtask

  task automatic sendBit(input logic b);
    Sample_Valid = 1'b1; Sample_Data = b;
    idleCycle();
    Sample_Valid = 1'b0; Sample_Data = 1'b0;
  endtask

  task automatic abortPulse();
    Abort = 1'b1;
    idleCycle();
    Abort = 1'b0;
  endtask

  // serial[i] is the i-th strobed bit after the start bit (data, optional parity, stop bits).
  task automatic applyStimulus(input logic [15:0] serial, input int n, input logic pe, input logic pt,
                               input logic [8:0] expData, input logic expPe, input logic expSe,
                               input int injectStartAt);
    exp_t e;
    startFrame(pe, pt, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) begin
        e.data = expData; e.pe = expPe; e.se = expSe; e.due = cyc + 1;
        sbq.push_back(e);
        sendBit(serial[i]);
      end else begin
        sendBit(serial[i]);
        Start_Det = (i == injectStartAt);
        idleCycle();
        Start_Det = 1'b0;
      end
    end
  endtask

  task automatic partialFrame(input logic [3:0] bits4);
    startFrame(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      sendBit(bits4[i]);
      idleCycle();
    end
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_data", 32'(pd0), 32'h0);
    checkOutput("reset_dv", 32'(dv0), 32'h0);
    checkOutput("reset_flags", 32'({pe0, se0, ov0}), 32'h0);
    checkOutput("reset_busy", 32'(bz0), 32'h0);
    RST = 1'b0;
    idleCycle();

    sel = 0;
    startFrame(1'b0, 1'b0, 1'b0);
    checkOutput("busy_in_frame", 32'(monBusy), 32'd1);
    abortPulse();
    applyStimulus(16'h1A5, 9, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0, -1);
    checkOutput("busy_after_frame", 32'(monBusy), 32'd0);
    applyStimulus(16'h103, 9, 1'b0, 1'b0, 9'h003, 1'b0, 1'b0, -1);

    applyStimulus(16'h303, 10, 1'b1, 1'b0, 9'h003, 1'b1, 1'b0, -1);
    applyStimulus(16'h203, 10, 1'b1, 1'b0, 9'h003, 1'b0, 1'b0, -1);
    applyStimulus(16'h303, 10, 1'b1, 1'b1, 9'h003, 1'b0, 1'b0, -1);
    applyStimulus(16'h0C1, 9, 1'b0, 1'b0, 9'h0C1, 1'b0, 1'b1, -1);
    idleCycle();

    abortPulse();
    sel = 1;
    applyStimulus(16'h15A, 10, 1'b0, 1'b0, 9'h05A, 1'b0, 1'b1, -1);
    applyStimulus(16'h35A, 10, 1'b0, 1'b0, 9'h05A, 1'b0, 1'b0, -1);
    idleCycle();

    abortPulse();
    sel = 2;
    applyStimulus(16'h0C1, 8, 1'b0, 1'b0, 9'h041, 1'b0, 1'b0, 3);
    applyStimulus(16'h083, 8, 1'b0, 1'b0, 9'h060, 1'b0, 1'b0, -1);
    idleCycle();

    abortPulse();
    sel = 0;
    applyStimulus(16'h1F0, 9, 1'b0, 1'b0, 9'h0F0, 1'b0, 1'b0, -1);
    partialFrame(4'b1011);
    Abort = 1'b1; Sample_Valid = 1'b1; Sample_Data = 1'b1;
    idleCycle();
    Abort = 1'b0; Sample_Valid = 1'b0; Sample_Data = 1'b0;
    checkOutput("abort_busy", 32'(monBusy), 32'd0);
    checkOutput("abort_hold_data", 32'(monData), 32'h0F0);
    Abort = 1'b1; Start_Det = 1'b1;
    idleCycle();
    Abort = 1'b0; Start_Det = 1'b0;
    checkOutput("abort_idle_start", 32'(monBusy), 32'd0);
    applyStimulus(16'h13C, 9, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b0, -1);
    idleCycle();

    partialFrame(4'b0110);
    RST = 1'b1;
    #2;
    checkOutput("rst_mid_data", 32'(monData), 32'h0);
    checkOutput("rst_mid_dv", 32'(monDv), 32'h0);
    checkOutput("rst_mid_flags", 32'({monPe, monSe, monOv}), 32'h0);
    checkOutput("rst_mid_busy", 32'(monBusy), 32'h0);
    idleCycle();
    RST = 1'b0;
    idleCycle();
    applyStimulus(16'h303, 10, 1'b1, 1'b0, 9'h003, 1'b1, 1'b0, -1);
    idleCycle();

`ifdef UART_RX_DESER_HOLD_EN
    RST = 1'b1;
    idleCycle();
    RST = 1'b0;
    idleCycle();
    applyStimulus(16'h111, 9, 1'b0, 1'b0, 9'h011, 1'b0, 1'b0, -1);
    checkOutput("hold_no_overrun", 32'(monOv), 32'd0);
    applyStimulus(16'h122, 9, 1'b0, 1'b0, 9'h022, 1'b0, 1'b0, -1);
    checkOutput("hold_overrun", 32'(monOv), 32'd1);
    checkOutput("hold_dv_level", 32'(monDv), 32'd1);
    checkOutput("hold_data", 32'(monData), 32'h022);
    Rd_Ack = 1'b1;
    idleCycle();
    Rd_Ack = 1'b0;
    checkOutput("ack_clears_dv", 32'(monDv), 32'd0);
    checkOutput("ack_clears_overrun", 32'(monOv), 32'd0);
`endif

    repeat (4) idleCycle();
    checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got cycle %0d, expected finish earlier", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
